// File: rtl/md_audio_mixer.sv
// md_audio_mixer: N-channel time-multiplexed gain/pan/saturating audio mixer, one channel per clock.
// Define MIXER_ROUND_EN for round-half-up gain products instead of truncation.
module md_audio_mixer #(
   parameter int CH = 4,
   parameter int IW = 16,
   parameter int OW = 16,
   parameter int GW = 8
) (
   input  logic             MCLK,
   input  logic             reset,
   input  logic             smp_strobe,
   input  logic [CH*IW-1:0] ch_data,
   input  logic [CH*GW-1:0] ch_gain,
   input  logic [2*CH-1:0]  ch_pan,
   input  logic             clip_clr,
   output logic             busy,
   output logic             out_valid,
   output logic [OW-1:0]    out_l,
   output logic [OW-1:0]    out_r,
   output logic             clip_l,
   output logic             clip_r,
   output logic             overrun
);
   localparam int AW = IW + 2 + $clog2(CH);
   localparam int PW = IW + GW + 1;
   localparam int XW = (AW > OW ? AW : OW) + 1;
   localparam int NW = $clog2(CH);
`ifdef MIXER_ROUND_EN
   localparam logic signed [PW-1:0] RND = (GW > 1) ? PW'(1) << ((GW > 1) ? GW - 2 : 0) : '0;
`else
   localparam logic signed [PW-1:0] RND = '0;
`endif
   localparam logic signed [XW-1:0] MAXV = XW'({(OW-1){1'b1}});
   localparam logic signed [XW-1:0] MINV = ~MAXV;

   typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

   state_t                 state_q, state_d;
   logic [NW-1:0]          idx_q, idx_d;
   logic [CH*IW-1:0]       data_q, data_d;
   logic [CH*GW-1:0]       gain_q, gain_d;
   logic [2*CH-1:0]        pan_q, pan_d;
   logic signed [AW-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [OW-1:0]          out_l_q, out_l_d, out_r_q, out_r_d;
   logic                   out_valid_q, out_valid_d, busy_q, busy_d;
   logic                   clip_l_q, clip_l_d, clip_r_q, clip_r_d, overrun_q, overrun_d;
   logic signed [IW-1:0]   smp;
   logic [GW-1:0]          gn;
   logic signed [PW-1:0]   prod;
   logic signed [AW-1:0]   p;
   logic [OW:0]            sat_l, sat_r;

   // {clipped, clamped value}; widened so the bounds compare correctly for any OW vs AW
   function automatic logic [OW:0] clamp(input logic signed [AW-1:0] a);
      logic signed [XW-1:0] x;
      x = XW'(a);
      return (x > MAXV) ? {1'b1, MAXV[OW-1:0]} : (x < MINV) ? {1'b1, MINV[OW-1:0]} : {1'b0, x[OW-1:0]};
   endfunction

   always_comb begin
      smp = data_q[int'(idx_q)*IW +: IW];
      gn = gain_q[int'(idx_q)*GW +: GW];
      prod = smp * $signed({1'b0, gn}) + RND;
      p = AW'(prod >>> (GW - 1));
      sat_l = clamp(acc_l_q);
      sat_r = clamp(acc_r_q);
      state_d = state_q;
      idx_d = idx_q;
      data_d = data_q;
      gain_d = gain_q;
      pan_d = pan_q;
      acc_l_d = acc_l_q;
      acc_r_d = acc_r_q;
      out_l_d = out_l_q;
      out_r_d = out_r_q;
      out_valid_d = 1'b0;
      clip_l_d = clip_l_q & ~clip_clr;
      clip_r_d = clip_r_q & ~clip_clr;
      overrun_d = (smp_strobe && state_q != IDLE) | (overrun_q & ~clip_clr);
      case (state_q)
         IDLE: if (smp_strobe) begin
            data_d = ch_data;
            gain_d = ch_gain;
            pan_d = ch_pan;
            acc_l_d = '0;
            acc_r_d = '0;
            idx_d = '0;
            state_d = ACC;
         end
         ACC: begin
            acc_l_d = acc_l_q + (pan_q[2*int'(idx_q)] ? p : '0);
            acc_r_d = acc_r_q + (pan_q[2*int'(idx_q)+1] ? p : '0);
            idx_d = idx_q + 1'b1;
            state_d = (idx_q == NW'(CH - 1)) ? SAT : ACC;
         end
         SAT: begin
            out_l_d = sat_l[OW-1:0];
            out_r_d = sat_r[OW-1:0];
            clip_l_d = sat_l[OW] | clip_l_d;
            clip_r_d = sat_r[OW] | clip_r_d;
            out_valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge MCLK) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q <= '0;
         data_q <= '0;
         gain_q <= '0;
         pan_q <= '0;
         acc_l_q <= '0;
         acc_r_q <= '0;
         out_l_q <= '0;
         out_r_q <= '0;
         out_valid_q <= 1'b0;
         busy_q <= 1'b0;
         clip_l_q <= 1'b0;
         clip_r_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         data_q <= data_d;
         gain_q <= gain_d;
         pan_q <= pan_d;
         acc_l_q <= acc_l_d;
         acc_r_q <= acc_r_d;
         out_l_q <= out_l_d;
         out_r_q <= out_r_d;
         out_valid_q <= out_valid_d;
         busy_q <= busy_d;
         clip_l_q <= clip_l_d;
         clip_r_q <= clip_r_d;
         overrun_q <= overrun_d;
      end
   end

   assign busy = busy_q;
   assign out_valid = out_valid_q;
   assign out_l = out_l_q;
   assign out_r = out_r_q;
   assign clip_l = clip_l_q;
   assign clip_r = clip_r_q;
   assign overrun = overrun_q;
endmodule

// File: tb/tb_md_audio_mixer.sv
// tb_md_audio_mixer: directed plus random stimulus against a per-mix arithmetic model of md_audio_mixer.
module tb_md_audio_mixer;
   localparam int CH = 4, IW = 16, OW = 16, GW = 8;

   logic MCLK = 0, reset = 1, smp_strobe = 0, clip_clr = 0;
   logic [CH*IW-1:0] ch_data = '0;
   logic [CH*GW-1:0] ch_gain = '0;
   logic [2*CH-1:0] ch_pan = '0;
   logic busy, out_valid, clip_l, clip_r, overrun;
   logic [OW-1:0] out_l, out_r;
   int tests = 0, fails = 0, nvalid = 0;

   int m_left = 0;
   longint m_l = 0, m_r = 0, p_l = 0, p_r = 0;
   bit m_valid = 0, m_busy = 0, m_cl = 0, m_cr = 0, m_ov = 0, p_cl = 0, p_cr = 0;

   always #5 MCLK = ~MCLK;

   md_audio_mixer #(.CH(CH), .IW(IW), .OW(OW), .GW(GW)) dut (
      .MCLK(MCLK), .reset(reset), .smp_strobe(smp_strobe), .ch_data(ch_data), .ch_gain(ch_gain),
      .ch_pan(ch_pan), .clip_clr(clip_clr), .busy(busy), .out_valid(out_valid), .out_l(out_l),
      .out_r(out_r), .clip_l(clip_l), .clip_r(clip_r), .overrun(overrun));

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   // whole-mix arithmetic: scaled products, routed sums, clamp to OW
   task automatic mixcalc(input logic [CH*IW-1:0] d, input logic [CH*GW-1:0] g, input logic [2*CH-1:0] pn,
                          output longint l, output longint r, output bit cl, output bit cr);
      longint sl, sr, s, pr;
      sl = 0;
      sr = 0;
      for (int k = 0; k < CH; k++) begin
         s = longint'($signed(d[k*IW +: IW]));
         pr = s * longint'(g[k*GW +: GW]);
`ifdef MIXER_ROUND_EN
         pr = pr + (longint'(1) << (GW - 2));
`endif
         pr = pr >>> (GW - 1);
         if (pn[2*k]) sl += pr;
         if (pn[2*k+1]) sr += pr;
      end
      cl = (sl > 32767) || (sl < -32768);
      cr = (sr > 32767) || (sr < -32768);
      l = (sl > 32767) ? 32767 : (sl < -32768) ? -32768 : sl;
      r = (sr > 32767) ? 32767 : (sr < -32768) ? -32768 : sr;
   endtask

   initial forever begin
      @(posedge MCLK);
      if (reset) begin
         m_left = 0; m_l = 0; m_r = 0; m_valid = 0; m_cl = 0; m_cr = 0; m_ov = 0;
      end else begin : mdl
         bit sl, sr, so;
         sl = 0; sr = 0; so = 0; m_valid = 0;
         if (m_left > 0) begin
            so = smp_strobe;
            m_left--;
            if (m_left == 0) begin
               m_l = p_l; m_r = p_r; m_valid = 1; sl = p_cl; sr = p_cr;
            end
         end else if (smp_strobe) begin
            mixcalc(ch_data, ch_gain, ch_pan, p_l, p_r, p_cl, p_cr);
            m_left = CH + 1;
         end
         m_cl = sl | (m_cl & !clip_clr);
         m_cr = sr | (m_cr & !clip_clr);
         m_ov = so | (m_ov & !clip_clr);
      end
      m_busy = (m_left > 0);
   end

   initial forever begin
      @(negedge MCLK);
      if (out_valid) nvalid++;
      chk("busy", longint'(busy), longint'(m_busy));
      chk("out_valid", longint'(out_valid), longint'(m_valid));
      chk("out_l", longint'($signed(out_l)), m_l);
      chk("out_r", longint'($signed(out_r)), m_r);
      chk("clip_l", longint'(clip_l), longint'(m_cl));
      chk("clip_r", longint'(clip_r), longint'(m_cr));
      chk("overrun", longint'(overrun), longint'(m_ov));
   end

   task automatic go(input logic [CH*IW-1:0] d, input logic [CH*GW-1:0] g, input logic [2*CH-1:0] pn);
      @(posedge MCLK); #2;
      ch_data = d; ch_gain = g; ch_pan = pn; smp_strobe = 1;
      @(posedge MCLK); #2;
      smp_strobe = 0; ch_data = {$urandom, $urandom}; ch_gain = $urandom; ch_pan = $urandom;
   endtask

   task automatic wait_valid(output int n, output int nb);
      n = 0; nb = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge MCLK);
         if (out_valid) begin n = i; break; end
         if (busy) nb++;
      end
   endtask

   task automatic run(input string nm, input logic [CH*IW-1:0] d, input logic [CH*GW-1:0] g,
                      input logic [2*CH-1:0] pn, input longint el, input longint er);
      int n, nb;
      go(d, g, pn);
      wait_valid(n, nb);
      chk({nm, "_latency"}, n, 6);
      chk({nm, "_l"}, longint'($signed(out_l)), el);
      chk({nm, "_r"}, longint'($signed(out_r)), er);
   endtask

   task automatic pulse_clr();
      @(posedge MCLK); #2 clip_clr = 1;
      @(posedge MCLK); #2 clip_clr = 0;
      @(negedge MCLK);
   endtask

   initial begin
      int n, nb, v;
      repeat (3) @(posedge MCLK);
      #2 reset = 0;
      @(negedge MCLK);
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_out_l", out_l, 0);
      chk("rst_overrun", overrun, 0);

      go({16'h0, 16'h0, 16'h0, 16'h1000}, {8'd0, 8'd0, 8'd0, 8'd128}, 8'b0000_0011);
      wait_valid(n, nb);
      chk("unity_latency", n, 6);
      chk("unity_busy_cycles", nb, 5);
      chk("unity_busy_in_valid", busy, 0);
      chk("unity_l", out_l, 16'h1000);
      chk("unity_r", out_r, 16'h1000);

      run("pan", {16'h0, 16'h0, 16'hFFCE, 16'd100}, {8'd0, 8'd0, 8'd128, 8'd128}, 8'b0000_1001, 100, -50);
      run("g64", {16'h0, 16'h0, 16'h0, 16'h0100}, {8'd0, 8'd0, 8'd0, 8'd64}, 8'b11, 128, 128);
      run("g255", {16'h0, 16'h0, 16'h0, 16'h0100}, {8'd0, 8'd0, 8'd0, 8'd255}, 8'b11, 510, 510);
`ifdef MIXER_ROUND_EN
      run("neg3", {16'h0, 16'h0, 16'h0, 16'hFFFD}, {8'd0, 8'd0, 8'd0, 8'd64}, 8'b11, -1, -1);
`else
      run("neg3", {16'h0, 16'h0, 16'h0, 16'hFFFD}, {8'd0, 8'd0, 8'd0, 8'd64}, 8'b11, -2, -2);
`endif
      chk("no_clip_yet", clip_l, 0);
      run("sat_pos", {4{16'h7000}}, {4{8'd128}}, 8'hFF, 32767, 32767);
      chk("sat_pos_clip_l", clip_l, 1);
      chk("sat_pos_clip_r", clip_r, 1);
      run("sat_neg", {4{16'h9000}}, {4{8'd128}}, 8'hFF, -32768, -32768);
      run("small", {16'h0, 16'h0, 16'h0, 16'h0010}, {8'd0, 8'd0, 8'd0, 8'd128}, 8'b11, 16, 16);
      chk("clip_l_sticky", clip_l, 1);
      chk("clip_r_sticky", clip_r, 1);
      pulse_clr();
      chk("clip_l_cleared", clip_l, 0);
      chk("clip_r_cleared", clip_r, 0);

      for (int i = 0; i < 4; i++) begin
         @(posedge MCLK); #2;
         ch_data = {$urandom, $urandom}; ch_gain = $urandom; ch_pan = $urandom; smp_strobe = 1;
         @(posedge MCLK); #2 smp_strobe = 0;
         repeat (4) @(posedge MCLK);
      end
      repeat (3) @(negedge MCLK);
      chk("period6_overrun", overrun, 0);

      go({16'h0, 16'h0, 16'h0, 16'h0200}, {8'd0, 8'd0, 8'd0, 8'd128}, 8'b11);
      @(posedge MCLK); #2;
      ch_data = {4{16'h7000}}; ch_gain = {4{8'd128}}; ch_pan = 8'hFF; smp_strobe = 1;
      @(posedge MCLK); #2 smp_strobe = 0;
      wait_valid(n, nb);
      chk("ovr_valid_seen", n > 0, 1);
      chk("ovr_first_l", out_l, 16'h0200);
      chk("ovr_first_r", out_r, 16'h0200);
      chk("ovr_flag", overrun, 1);
      chk("ovr_no_clip", clip_l, 0);
      pulse_clr();
      chk("ovr_cleared", overrun, 0);

      go({16'h0, 16'h0, 16'h0, 16'h0300}, {8'd0, 8'd0, 8'd0, 8'd128}, 8'b11);
      @(posedge MCLK); #2 reset = 1;
      @(posedge MCLK); #2 reset = 0;
      @(negedge MCLK);
      chk("rmid_busy", busy, 0);
      chk("rmid_out_l", out_l, 0);
      n = 0;
      repeat (10) begin
         @(negedge MCLK);
         if (out_valid) n++;
      end
      chk("rmid_no_valid", n, 0);
      run("after_reset", {16'h0, 16'h0, 16'h0, 16'h0040}, {8'd0, 8'd0, 8'd0, 8'd128}, 8'b10, 0, 64);

      repeat (1500) begin
         @(posedge MCLK); #2;
         for (int k = 0; k < CH; k++) begin
            v = $urandom_range(0, 3);
            ch_data[k*IW +: IW] = (v == 0) ? 16'h7FFF : (v == 1) ? 16'h8000 : 16'($urandom);
            v = $urandom_range(0, 3);
            ch_gain[k*GW +: GW] = (v == 0) ? 8'd0 : (v == 1) ? 8'd128 : (v == 2) ? 8'd255 : 8'($urandom);
         end
         ch_pan = $urandom;
         smp_strobe = ($urandom_range(0, 3) == 0);
         clip_clr = ($urandom_range(0, 40) == 0);
         reset = ($urandom_range(0, 400) == 0);
      end
      @(posedge MCLK); #2;
      smp_strobe = 0; clip_clr = 0; reset = 0;
      repeat (10) @(negedge MCLK);
      chk("random_valids_seen", nvalid > 100, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
